// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: on a start edge, reads mem[pc] into instr and bumps pc, answering with a one-cycle done (zero-wait fetch: done 2 cycles after start).
// Backpressure: holds mem_rd and mem_addr until mem_ready, giving up with a sticky fault after TIMEOUT wait cycles.
module instr_fetch_seq #(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 16,
  parameter int          RESET_PC = 0,
  parameter int          TIMEOUT  = 15,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic              done,
  output logic              busy,
  output logic              fault,
  output logic              halted
);

  generate
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("instr_fetch_seq: TIMEOUT must be in 1..255");
    end
    if (DATA_W < 4) begin : g_bad_data_w
      $error("instr_fetch_seq: DATA_W must hold a 4-bit opcode");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Last counter value of the wait window; WAIT therefore lasts TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_start_q;
  logic              w_start_rise;
  logic [7:0]        r_cnt;
  logic              r_ok;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;
  logic              r_fault;
  logic              r_halted;
  logic              w_capture;
  logic              w_timeout;

  assign w_start_rise = start & ~r_start_q;

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise && !r_halted && !r_fault) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_q <= start;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_REQ) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // r_ok remembers whether the fetch ending in DONE actually returned data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ok    <= 1'b0;
      r_instr <= '0;
    end else if (w_capture) begin
      r_ok    <= 1'b1;
      r_instr <= mem_rdata;
    end else if (w_timeout) begin
      r_ok    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (r_state == S_IDLE && pc_load) begin
      r_pc <= pc_load_val;
    end else if (r_state == S_DONE && r_ok) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_fault <= 1'b1;
      end
      if (r_state == S_DONE && r_instr[DATA_W-1 -: 4] == HALT_OP) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign mem_rd   = (r_state == S_REQ) || (r_state == S_WAIT);
  assign mem_addr = r_pc;
  assign done     = (r_state == S_DONE);
  assign busy     = (r_state != S_IDLE);
  assign instr    = r_instr;
  assign pc       = r_pc;
  assign fault    = r_fault;
  assign halted   = r_halted;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed scenarios plus random fetches against a transaction-level model.
module tb_instr_fetch_seq;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] instr;
  logic [AW-1:0] pc;
  logic          done;
  logic          busy;
  logic          fault;
  logic          halted;

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model state.
  logic [AW-1:0] pc_m;
  logic [DW-1:0] instr_m;
  logic          fault_m;
  logic          halted_m;

  instr_fetch_seq #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .TIMEOUT(TO), .HALT_OP(4'hF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr(instr), .pc(pc), .done(done), .busy(busy), .fault(fault), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; pc_load = 1'b0; pc_load_val = '0; mem_ready = 1'b0; mem_rdata = '0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pc_m = '0; instr_m = '0; fault_m = 1'b0; halted_m = 1'b0;
  endtask

  // One start edge; memory answers on the lat-th mem_rd cycle (0 = in REQ). Checks every cycle.
  task automatic run_fetch(input int lat, input logic [DW-1:0] data, input bit ld,
                           input logic [AW-1:0] ldv, input bit hold, input bit noise);
    bit            fetch;
    bit            ok;
    int            done_at;
    int            last;
    logic [AW-1:0] addr_exp;
    bit            exp_rd;
    bit            exp_done;
    bit            exp_busy;
    @(negedge clk);
    start = 1'b1; pc_load = ld; pc_load_val = ldv;
    mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata = 16'($urandom);
    if (ld) pc_m = ldv;
    fetch    = !halted_m && !fault_m;
    ok       = (lat <= TO);
    done_at  = !fetch ? 0 : (ok ? 2 + lat : 2 + TO);
    last     = fetch ? done_at + 2 : 4;
    addr_exp = pc_m;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      exp_rd   = fetch && c < done_at;
      exp_done = fetch && c == done_at;
      exp_busy = fetch && c <= done_at;
      vectors++;
      if (mem_rd !== exp_rd) begin
        miscompares++;
        $display("FAIL mem_rd cycle %0d: got %b want %b", c, mem_rd, exp_rd);
      end
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("FAIL done cycle %0d: got %b want %b", c, done, exp_done);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL busy cycle %0d: got %b want %b", c, busy, exp_busy);
      end
      if (exp_rd) begin
        vectors++;
        if (mem_addr !== addr_exp) begin
          miscompares++;
          $display("FAIL mem_addr cycle %0d: got %h want %h", c, mem_addr, addr_exp);
        end
      end
      start       = hold && c < last;
      pc_load     = (fetch && c <= done_at && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
      pc_load_val = 8'($urandom);
      if (fetch && c < done_at) mem_ready = (c - 1 == lat);
      else                      mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = (fetch && c - 1 == lat) ? data : 16'($urandom);
    end
    if (fetch) begin
      if (ok) begin
        instr_m = data;
        pc_m    = pc_m + 8'd1;
        if (data[15:12] == 4'hF) halted_m = 1'b1;
      end else begin
        fault_m = 1'b1;
      end
    end
    vectors++;
    if (pc !== pc_m) begin
      miscompares++;
      $display("FAIL pc after fetch: got %h want %h", pc, pc_m);
    end
    vectors++;
    if (instr !== instr_m) begin
      miscompares++;
      $display("FAIL instr after fetch: got %h want %h", instr, instr_m);
    end
    vectors++;
    if (fault !== fault_m || halted !== halted_m) begin
      miscompares++;
      $display("FAIL flags after fetch: got fault=%b halted=%b want fault=%b halted=%b",
               fault, halted, fault_m, halted_m);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({mem_rd, done, busy, fault, halted} !== 5'b0 || pc !== 8'h00 || instr !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_state: got rd=%b done=%b busy=%b fault=%b halted=%b pc=%h instr=%h want all zero",
               mem_rd, done, busy, fault, halted, pc, instr);
    end
  endtask

  task automatic test_basic();
    run_fetch(0, 16'h1234, 1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (pc !== 8'h01 || instr !== 16'h1234) begin
      miscompares++;
      $display("FAIL basic_fetch: got pc=%h instr=%h want pc=01 instr=1234", pc, instr);
    end
  endtask

  task automatic test_wait_states();
    run_fetch(3, 16'h2345, 1'b0, 8'h00, 1'b1, 1'b1);
    vectors++;
    if (pc !== 8'h02 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_fetch: got pc=%h fault=%b want pc=02 fault=0", pc, fault);
    end
  endtask

  task automatic test_timeout();
    run_fetch(TO + 50, 16'h5555, 1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (fault !== 1'b1 || pc !== 8'h02 || instr !== 16'h2345) begin
      miscompares++;
      $display("FAIL timeout: got fault=%b pc=%h instr=%h want fault=1 pc=02 instr=2345", fault, pc, instr);
    end
    run_fetch(0, 16'h7777, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midfetch();
    @(negedge clk);
    start = 1'b1; pc_load = 1'b1; pc_load_val = 8'h40; mem_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      pc_load = 1'b0;
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (mem_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got rd=%b busy=%b done=%b pc=%h want 0 0 0 00", mem_rd, busy, done, pc);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pc_m = '0; instr_m = '0; fault_m = 1'b0; halted_m = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle cycle %0d: got done=%b busy=%b want 0 0", c, done, busy);
      end
    end
  endtask

  task automatic test_pc_wrap();
    run_fetch(1, 16'h0ABC, 1'b1, 8'hFF, 1'b0, 1'b1);
    vectors++;
    if (pc !== 8'h00) begin
      miscompares++;
      $display("FAIL pc_wrap: got %h want 00", pc);
    end
  endtask

  task automatic test_halt();
    run_fetch(2, 16'hF000, 1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_flag: got %b want 1", halted);
    end
    run_fetch(0, 16'h1111, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    int            lat;
    logic [DW-1:0] data;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if ((fault_m || halted_m) && $urandom_range(0, 1) == 1) do_reset();
      lat  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 3)) : int'($urandom_range(0, 3));
      data = 16'($urandom);
      if ($urandom_range(0, 9) != 0 && data[15:12] == 4'hF) data[15] = 1'b0;
      run_fetch(lat, data, $urandom_range(0, 3) == 0, 8'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pc_load = 1'b0; pc_load_val = '0; mem_ready = 1'b0; mem_rdata = '0;
    pc_m = '0; instr_m = '0; fault_m = 1'b0; halted_m = 1'b0;
    test_reset();
    test_basic();
    test_wait_states();
    test_timeout();
    test_reset_midfetch();
    test_pc_wrap();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
